apb_slave_mem: RTL and testbench

APB3 completer (slave) that terminates transfers issued by the AHB-to-APB bridge. It holds a bank of 32-bit registers and one wait-state configuration register, inserts a programmable number of wait states per transfer, and signals `pslverr` on misaligned or unmapped addresses. It serves as the bench target behind the bridge and as a simple on-chip peripheral.

---
 rtl/apb_slave_mem.sv | 200 ++++++++++++++++++++
 tb/tb_apb_slave_mem.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// -----------------------------------------------------------------------------
// apb_slave_mem
//
// APB3 completer holding a bank of DEPTH 32-bit storage words and one
// wait-state configuration register (WAIT_CFG). Each transfer is stretched
// by WAIT_CFG wait states. Misaligned or unmapped accesses complete with
// pslverr and leave every register untouched.
//
// Address map (byte offsets from BASE_ADDR):
//   0x000 .. 4*DEPTH-4 : storage words
//   0x100              : WAIT_CFG, bits [3:0] writable, read zero-extended
//   anything else      : error response
//
// Parameters:
//   ADDR_WIDTH : width of paddr (at least 10)
//   DATA_WIDTH : width of pwdata / prdata (at least 5)
//   DEPTH      : number of storage words, power of two, 2..256
//   BASE_ADDR  : byte base address, aligned to 512 bytes
//
// Ports:
//   hclk     in  : clock, all state changes on the rising edge
//   hreset   in  : asynchronous active-high reset
//   psel     in  : completer select
//   penable  in  : access-phase indicator
//   pwrite   in  : 1 = write, 0 = read
//   paddr    in  : byte address, sampled in the setup phase only
//   pwdata   in  : write data, sampled in the setup phase only
//   prdata   out : read data, non-zero only in the pready cycle
//   pready   out : transfer completes in this cycle
//   pslverr  out : error response, only in the pready cycle
// -----------------------------------------------------------------------------
module apb_slave_mem #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Byte span of the storage array and the offset of WAIT_CFG.
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(4 * DEPTH);
    localparam logic [ADDR_WIDTH-1:0] CFG_OFF   = ADDR_WIDTH'(12'h100);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [3:0]            cnt;
    logic [3:0]            cnt_next;
    logic                  capture;

    logic [3:0]            wait_cfg;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Transfer attributes latched in the setup phase.
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    // Decode results, all derived from the captured address.
    logic [ADDR_WIDTH-1:0] offset;
    logic                  aligned;
    logic                  hit_cfg;
    logic                  hit_mem;
    logic                  addr_err;
    logic [IDX_W-1:0]      idx;

    logic                  mem_we;
    logic                  cfg_we;
    logic [DATA_WIDTH-1:0] cfg_rdata;

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    // An address below BASE_ADDR wraps to a huge offset and therefore falls
    // outside both windows, which makes it an error without a separate check.
    // WAIT_CFG takes priority so large DEPTH values cannot shadow it.
    always_comb begin
        offset   = addr_q - BASE_ADDR;
        aligned  = (offset[1:0] == 2'b00);
        hit_cfg  = aligned && (offset == CFG_OFF);
        hit_mem  = aligned && !hit_cfg && (offset < MEM_BYTES);
        addr_err = !(hit_cfg || hit_mem);
        idx      = offset[IDX_W+1:2];
    end

    assign cfg_rdata = {{(DATA_WIDTH-4){1'b0}}, wait_cfg};

    // -------------------------------------------------------------------------
    // Transfer state machine: next-state logic
    // -------------------------------------------------------------------------
    // penable high while idle is a protocol violation and is simply ignored:
    // only a proper setup phase (psel & !penable) starts a transfer.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    capture    = 1'b1;
                    cnt_next   = wait_cfg;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    // Abort: leave without touching any register.
                    state_next = IDLE;
                end else if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else if (penable) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Transfer state machine: state, wait counter and captured request
    // -------------------------------------------------------------------------
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (capture) begin
                addr_q  <= paddr;
                write_q <= pwrite;
                wdata_q <= pwdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Completion handshake and response
    // -------------------------------------------------------------------------
    assign pready  = (state == ACCESS) && (cnt == 4'd0) && psel && penable;
    assign pslverr = pready && addr_err;

    always_comb begin
        prdata = '0;
        if (pready) begin
            if (hit_mem) begin
                prdata = mem[idx];
            end else if (hit_cfg) begin
                prdata = cfg_rdata;
            end
        end
    end

    // Writes commit at the end of the pready cycle, so a setup phase right
    // after a WAIT_CFG write already loads the new wait count, and a read
    // right after a storage write sees the new data.
    assign mem_we = pready && write_q && hit_mem;
    assign cfg_we = pready && write_q && hit_cfg;

    // -------------------------------------------------------------------------
    // Register bank
    // -------------------------------------------------------------------------
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            wait_cfg <= 4'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (cfg_we) begin
                wait_cfg <= wdata_q[3:0];
            end
            if (mem_we) begin
                mem[idx] <= wdata_q;
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_mem
//
// Directed bench for apb_slave_mem (DEPTH=16, BASE_ADDR=0). Inputs are driven
// 1 time unit after the rising edge and outputs are sampled mid-cycle.
// -----------------------------------------------------------------------------
module tb_apb_slave_mem;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] rd;
    logic        er;
    int          acc;

    apb_slave_mem #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (16),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .hclk    (hclk),
        .hreset  (hreset),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    always #5 hclk = ~hclk;

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One full APB transfer starting at posedge+1. Returns read data and
    // error flag sampled in the pready cycle, and the number of access cycles
    // up to and including that cycle (-1 if pready never came). paddr and
    // pwdata are disturbed during the access phase on purpose.
    task automatic apb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rdat, output logic err, output int nacc);
        logic done;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = w;
        paddr   = a;
        pwdata  = d;
        @(posedge hclk); #1;
        penable = 1'b1;
        paddr   = a ^ 32'h0000_0004;
        pwdata  = ~d;
        nacc    = 0;
        rdat    = '0;
        err     = 1'b0;
        done    = 1'b0;
        for (int i = 0; i < 32 && !done; i++) begin
            #3;
            nacc++;
            if (pready) begin
                rdat = prdata;
                err  = pslverr;
                done = 1'b1;
            end
            @(posedge hclk); #1;
        end
        if (!done) nacc = -1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        hreset  = 1'b1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;

        // Reset state
        #12;
        chk("rst_pready",  32'(pready),  32'd0);
        chk("rst_prdata",  prdata,       32'd0);
        chk("rst_pslverr", 32'(pslverr), 32'd0);
        @(posedge hclk); #1;
        hreset = 1'b0;
        @(posedge hclk); #1;

        // Reset asserted in the access cycle of a write to word 2
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h08;
        pwdata  = 32'hDEAD_BEEF;
        @(posedge hclk); #1;
        penable = 1'b1;
        #3;
        chk("midrst_pre_pready", 32'(pready), 32'd1);
        hreset = 1'b1;
        #1;
        chk("midrst_pready",  32'(pready),  32'd0);
        chk("midrst_prdata",  prdata,       32'd0);
        chk("midrst_pslverr", 32'(pslverr), 32'd0);
        @(posedge hclk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        @(posedge hclk); #1;
        hreset = 1'b0;
        @(posedge hclk); #1;
        apb_xfer(1'b0, 32'h08, 32'h0, rd, er, acc);
        chk("midrst_rd_w2",  rd,       32'h0);
        chk("midrst_rd_err", 32'(er),  32'd0);
        chk("midrst_rd_acc", 32'(acc), 32'd1);

        // Zero-wait write then read of 0x0C, back-to-back
        apb_xfer(1'b1, 32'h0C, 32'h1234_5678, rd, er, acc);
        chk("w0c_acc", 32'(acc), 32'd1);
        chk("w0c_err", 32'(er),  32'd0);
        apb_xfer(1'b0, 32'h0C, 32'h0, rd, er, acc);
        chk("r0c_data", rd,       32'h1234_5678);
        chk("r0c_acc",  32'(acc), 32'd1);
        chk("r0c_err",  32'(er),  32'd0);

        // Wait states: only low nibble of WAIT_CFG is kept
        apb_xfer(1'b1, 32'h100, 32'hABCD_0003, rd, er, acc);
        chk("wcfg_acc", 32'(acc), 32'd1);
        chk("wcfg_err", 32'(er),  32'd0);
        apb_xfer(1'b0, 32'h00, 32'h0, rd, er, acc);
        chk("r00_acc",  32'(acc), 32'd4);
        chk("r00_data", rd,       32'h0);
        apb_xfer(1'b0, 32'h100, 32'h0, rd, er, acc);
        chk("rcfg_data", rd,       32'h0000_0003);
        chk("rcfg_acc",  32'(acc), 32'd4);

        // Last storage word is valid
        apb_xfer(1'b1, 32'h3C, 32'hCAFE_F00D, rd, er, acc);
        chk("w3c_err", 32'(er), 32'd0);
        apb_xfer(1'b0, 32'h3C, 32'h0, rd, er, acc);
        chk("r3c_data", rd,      32'hCAFE_F00D);
        chk("r3c_err",  32'(er), 32'd0);

        // Error responses
        apb_xfer(1'b1, 32'h40, 32'h5555_5555, rd, er, acc);
        chk("w40_err",  32'(er),  32'd1);
        chk("w40_data", rd,       32'h0);
        chk("w40_acc",  32'(acc), 32'd4);
        apb_xfer(1'b0, 32'h06, 32'h0, rd, er, acc);
        chk("r06_err",  32'(er), 32'd1);
        chk("r06_data", rd,      32'h0);
        apb_xfer(1'b1, 32'h104, 32'h0000_000F, rd, er, acc);
        chk("w104_err", 32'(er), 32'd1);
        apb_xfer(1'b1, 32'h101, 32'h0000_000F, rd, er, acc);
        chk("w101_err", 32'(er), 32'd1);
        apb_xfer(1'b0, 32'h0C, 32'h0, rd, er, acc);
        chk("err_keep_0c", rd, 32'h1234_5678);
        apb_xfer(1'b0, 32'h00, 32'h0, rd, er, acc);
        chk("err_keep_00", rd, 32'h0);
        apb_xfer(1'b0, 32'h100, 32'h0, rd, er, acc);
        chk("err_keep_cfg", rd, 32'h0000_0003);

        // Abort: WAIT_CFG=2, psel dropped in the second access cycle
        apb_xfer(1'b1, 32'h100, 32'h2, rd, er, acc);
        apb_xfer(1'b1, 32'h08, 32'h1111_2222, rd, er, acc);
        chk("w08_acc", 32'(acc), 32'd3);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h08;
        pwdata  = 32'hA5A5_A5A5;
        @(posedge hclk); #1;
        penable = 1'b1;
        #3;
        chk("abort_acc1_pready", 32'(pready), 32'd0);
        @(posedge hclk); #1;
        psel    = 1'b0;
        #3;
        chk("abort_acc2_pready", 32'(pready), 32'd0);
        @(posedge hclk); #1;
        penable = 1'b0;
        #3;
        chk("abort_after_pready", 32'(pready), 32'd0);
        @(posedge hclk); #1;
        apb_xfer(1'b0, 32'h08, 32'h0, rd, er, acc);
        chk("abort_r08_data", rd,       32'h1111_2222);
        chk("abort_r08_acc",  32'(acc), 32'd3);

        // Back-to-back with zero wait states
        apb_xfer(1'b1, 32'h100, 32'h0, rd, er, acc);
        chk("wcfg0_acc", 32'(acc), 32'd3);
        apb_xfer(1'b1, 32'h04, 32'h0000_0001, rd, er, acc);
        chk("b2b_w04_acc", 32'(acc), 32'd1);
        apb_xfer(1'b1, 32'h08, 32'h0000_0002, rd, er, acc);
        chk("b2b_w08_acc", 32'(acc), 32'd1);
        apb_xfer(1'b0, 32'h04, 32'h0, rd, er, acc);
        chk("b2b_r04_acc",  32'(acc), 32'd1);
        chk("b2b_r04_data", rd,       32'h0000_0001);
        apb_xfer(1'b0, 32'h08, 32'h0, rd, er, acc);
        chk("b2b_r08_data", rd, 32'h0000_0002);

        // penable high while idle is ignored
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 32'h0C;
        pwdata  = 32'h0000_0BAD;
        #3;
        chk("idle_pen_c1_pready", 32'(pready), 32'd0);
        @(posedge hclk); #1;
        #3;
        chk("idle_pen_c2_pready", 32'(pready), 32'd0);
        @(posedge hclk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        @(posedge hclk); #1;
        apb_xfer(1'b0, 32'h0C, 32'h0, rd, er, acc);
        chk("idle_pen_r0c", rd,       32'h1234_5678);
        chk("idle_pen_acc", 32'(acc), 32'd1);

        // Idle outputs stay low
        #3;
        chk("idle_prdata",  prdata,       32'd0);
        chk("idle_pslverr", 32'(pslverr), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
